encoder_4_2_seq: RTL
====================

Name: encoder_4_2_seq

Overview:
- Sequential 4-to-2 encoder, the inverse of the team's 2-to-4 decoder.
- Captures request events on the four one-hot lines D0..D3 into a sticky pending register.
- Selects one pending line by priority and presents its index on {A,B} (A = MSB) with a valid/ack handshake.
- Sits between request sources and any consumer that expects a 2-bit index, e.g. a downstream Decoder_2_4.

Parameters:
- EDGE_MODE, 1, 1 = capture rising edges of Dn only; 0 = capture level (Dn high in a sampled cycle).

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- en   input  1  capture enable; when 0, new Dn events are ignored
- D0   input  1  request line, index 0
- D1   input  1  request line, index 1
- D2   input  1  request line, index 2
- D3   input  1  request line, index 3
- ack  input  1  consumer accepts the current {A,B}
- A    output 1  encoded index MSB
- B    output 1  encoded index LSB
- V    output 1  {A,B} valid
- lost output 1  sticky; an event hit an already-pending line

Behaviour:
- Reset (rst=1 at a clk edge): pend=0000, d_q=0000, A=0, B=0, V=0, lost=0, state=IDLE. rst overrides every other input, mid-handshake included.
- Event vector: ev = EDGE_MODE ? (D & ~d_q) : D. d_q registers D every cycle, regardless of en.
- Served-clear vector clr: one-hot of {A,B} when state=HOLD and ack=1; otherwise 0000.
- Pending update: pend <= (pend & ~clr) | (en ? ev : 0000). When an event and a clear hit the same bit in the same cycle, set wins and that bit stays pending.
- lost <= lost | (en & |(ev & pend & ~clr)). Cleared only by rst.
- FSM, IDLE:
  - If pend != 0: register the selected index into {A,B}, V<=1, go to HOLD.
  - Otherwise V=0; A and B keep their last values.
  - ack is ignored in IDLE.
- FSM, HOLD:
  - V=1; A and B stay stable.
  - On ack=1: V<=0, go to IDLE. The served bit is cleared through clr.
  - Events arriving in HOLD only update pend; the output does not change until the next IDLE pass.
- Minimum gap of 1 cycle with V=0 between consecutive grants.
- Latency: an event sampled at edge n sets pend at n; V rises at edge n+1 if the FSM is idle.
- Fixed priority (default): D3 > D2 > D1 > D0. {A,B} = binary index of the highest set pend bit.
- en=0: already-pending requests continue to be served.

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN
- Defined:
  - A 2-bit pointer `last` (reset 00) records the index of each grant made on the IDLE->HOLD transition.
  - Selection searches pend in order last+1, last+2, last+3, last (mod 4), in ascending index. With last=00 after reset, the first search order is 1,2,3,0.
- Undefined: fixed priority as above; no pointer register.

Decomposition:
- Shared package/include encoder_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_HOLD=1'b1
  - IDX_W=2
  - LINES=4
- One combinational sub-module, prio_enc4:
  - inputs: req[3:0], base[1:0]
  - outputs: idx[1:0], any
  - Fixed mode ties base so the search order yields D3-first.

Test Plan:
- Reset, EDGE_MODE=1: rst=1 for 2 cycles -> A=0, B=0, V=0, lost=0. Pulse D2 for 1 cycle, en=1 -> V=1 exactly 2 edges later, {A,B}=10. ack=1 for 1 cycle -> V=0 on the next cycle, pend=0000.
- Priority: D1 and D3 pulse in the same cycle -> first grant {A,B}=11. After ack and a 1-cycle gap -> second grant {A,B}=01 (round-robin build: first grant 01, then 11).
- Hold stability: D0 granted, ack held low 10 cycles, D3 pulses mid-hold -> {A,B}=00 and V=1 unchanged throughout. After ack -> grant 11.
- Same-cycle set/clear: D2 granted; D2 pulses again in the ack cycle -> pend[2] remains set, regrant {A,B}=10, lost stays 0.
- Lost and en: D1 pulses twice while pend[1]=1 and V is on another index -> lost=1, and it stays 1 until rst. With en=0, a D0 pulse -> no grant, pend unchanged.
- Reset mid-operation: rst asserted in HOLD with pend=1011 -> next cycle V=0, pend=0000, no grant afterwards without new events.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and sizes for the sequential 4-to-2 encoder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package encoder_pkg;

    localparam int IDX_W = 2;
    localparam int LINES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // One-hot mask for a line index.
    function automatic logic [LINES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return LINES'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// Rotating priority encoder: first set req bit scanning base, base+1, base+2, base+3 (mod 4).
// Latency: purely combinational.
// Backpressure: none; any=0 means idx is don't-care (driven to 0).
module prio_enc4
    import encoder_pkg::*;
(
    input  logic [LINES-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Ascending scan from base; the first hit wins.
    always_comb begin
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        any   = |req;
        for (int i = 0; i < LINES; i++) begin
            cand = base + IDX_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_4_2_seq.sv
// Sequential 4-to-2 encoder: sticky request capture, priority select, index on {A,B} with V/ack.
// Latency: event at edge n pends at n, V rises at n+1 when idle; one V=0 cycle between grants.
// Backpressure: {A,B} held with V=1 until ack; new events only accumulate in pend (lost flags overlaps).
// Optional build macro ENCODER_ROUND_ROBIN_EN: round-robin selection after the last grant.
module encoder_4_2_seq
    import encoder_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic ack,
    output logic A,
    output logic B,
    output logic V,
    output logic lost
);

    logic [LINES-1:0] d_vec;
    logic [LINES-1:0] d_q;
    logic [LINES-1:0] ev;
    logic [LINES-1:0] clr;
    logic [LINES-1:0] pend;
    logic [LINES-1:0] pend_nxt;
    logic             lost_nxt;
    state_t           state;
    state_t           state_nxt;
    logic             a_nxt;
    logic             b_nxt;
    logic             v_nxt;
    logic [LINES-1:0] req;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W-1:0] grant_idx;
    logic             any;

    assign d_vec = {D3, D2, D1, D0};
    assign ev    = EDGE_MODE ? (d_vec & ~d_q) : d_vec;
    assign clr   = (state == ST_HOLD && ack) ? idx_onehot({A, B}) : '0;

    // A set and a clear on the same bit leave it pending (set is OR-ed in last).
    assign pend_nxt = (pend & ~clr) | (en ? ev : '0);
    assign lost_nxt = lost | (en & (|(ev & pend & ~clr)));

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last;

    // Remember each grant so the next search starts just after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= '0;
        end else if (state == ST_IDLE && any) begin
            last <= grant_idx;
        end
    end

    assign req       = pend;
    assign base      = last + IDX_W'(1);
    assign grant_idx = enc_idx;
`else
    // Fixed D3-first: scan the bit-reversed vector upward from 0, then
    // invert the found position back into a line index.
    assign req       = {pend[0], pend[1], pend[2], pend[3]};
    assign base      = '0;
    assign grant_idx = ~enc_idx;
`endif

    prio_enc4 u_prio (
        .req  (req),
        .base (base),
        .idx  (enc_idx),
        .any  (any)
    );

    // Request capture: input history, sticky pending set and overlap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            pend <= '0;
            lost <= 1'b0;
        end else begin
            d_q  <= d_vec;
            pend <= pend_nxt;
            lost <= lost_nxt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            A     <= 1'b0;
            B     <= 1'b0;
            V     <= 1'b0;
        end else begin
            state <= state_nxt;
            A     <= a_nxt;
            B     <= b_nxt;
            V     <= v_nxt;
        end
    end

    // Next state: grant from IDLE when anything pends, hold until ack.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        b_nxt     = B;
        v_nxt     = V;
        case (state)
            ST_IDLE: begin
                v_nxt = 1'b0;
                if (any) begin
                    {a_nxt, b_nxt} = grant_idx;
                    v_nxt          = 1'b1;
                    state_nxt      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                v_nxt = 1'b1;
                if (ack) begin
                    v_nxt     = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                v_nxt     = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
